// File: rtl/mempool_remote_link_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : mempool_remote_link_buffer (with helper mempool_link_fifo)
//  Description : Elastic pipeline stage on one inter-group TCDM link.
//                A registered request FIFO forwards requests from the
//                initiator group to the target group. A registered response
//                FIFO returns responses. An outstanding-transaction counter
//                throttles request acceptance so that every accepted request
//                is guaranteed a free response slot (MaxOutstanding must not
//                exceed RespDepth).
//  Ports       : clk_i / rst_i           clock, synchronous active-high reset
//                mst_req_*               request in  (valid/ready)
//                slv_req_*               request out (valid/ready)
//                slv_resp_*              response in (valid/ready)
//                mst_resp_*              response out (valid/ready)
//                outstanding_o           requests accepted but not answered
//                stall_req_cnt_o         (MEMPOOL_LINK_STATS_EN only)
//                stall_resp_cnt_o        (MEMPOOL_LINK_STATS_EN only)
//  Options     : define MEMPOOL_LINK_STATS_EN to add the two 32-bit stall
//                counters.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Registered (non fall-through) FIFO. Depth must be a power of two so the
// pointers wrap naturally; the extra count bit separates full from empty.
// The parent never pushes when full nor pops when empty.
// ----------------------------------------------------------------------------
module mempool_link_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] data_i,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned         c_PTR_W = $clog2(Depth);
    localparam int unsigned         c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH = c_CNT_W'(Depth);

    logic [Width-1:0]   mem_q [Depth];
    logic [c_PTR_W-1:0] wptr_q;
    logic [c_PTR_W-1:0] rptr_q;
    logic [c_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + c_PTR_W'(1);
            if (pop_i)  rptr_q <= rptr_q + c_PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + c_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - c_CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset: entries are only observed while count > 0.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == c_DEPTH);
endmodule

module mempool_remote_link_buffer #(
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RespWidth      = 48,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned RespDepth      = 4,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [ReqWidth-1:0]                   mst_req_i,
    input  logic                                  mst_req_valid_i,
    output logic                                  mst_req_ready_o,
    output logic [ReqWidth-1:0]                   slv_req_o,
    output logic                                  slv_req_valid_o,
    input  logic                                  slv_req_ready_i,
    input  logic [RespWidth-1:0]                  slv_resp_i,
    input  logic                                  slv_resp_valid_i,
    output logic                                  slv_resp_ready_o,
    output logic [RespWidth-1:0]                  mst_resp_o,
    output logic                                  mst_resp_valid_o,
    input  logic                                  mst_resp_ready_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
`ifdef MEMPOOL_LINK_STATS_EN
    ,
    output logic [31:0]                           stall_req_cnt_o,
    output logic [31:0]                           stall_resp_cnt_o
`endif
);
    localparam int unsigned         c_OUT_W   = $clog2(MaxOutstanding + 1);
    localparam logic [c_OUT_W-1:0]  c_OUT_MAX = c_OUT_W'(MaxOutstanding);

    logic               w_req_push;
    logic               w_req_pop;
    logic               w_req_empty;
    logic               w_req_full;
    logic               w_resp_push;
    logic               w_resp_pop;
    logic               w_resp_empty;
    logic               w_resp_full;
    logic [c_OUT_W-1:0] outstanding_q;
    logic [c_OUT_W-1:0] outstanding_d;

    // Acceptance depends only on registered state (and reset), never on the
    // downstream ready, so no combinational path crosses the stage.
    assign mst_req_ready_o  = !rst_i && !w_req_full && (outstanding_q < c_OUT_MAX);
    assign slv_req_valid_o  = !w_req_empty;
    assign slv_resp_ready_o = !rst_i && !w_resp_full;
    assign mst_resp_valid_o = !w_resp_empty;

    assign w_req_push  = mst_req_valid_i  && mst_req_ready_o;
    assign w_req_pop   = slv_req_valid_o  && slv_req_ready_i;
    assign w_resp_push = slv_resp_valid_i && slv_resp_ready_o;
    assign w_resp_pop  = mst_resp_valid_o && mst_resp_ready_i;

    mempool_link_fifo #(
        .Width (ReqWidth),
        .Depth (ReqDepth)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (mst_req_i),
        .push_i  (w_req_push),
        .pop_i   (w_req_pop),
        .data_o  (slv_req_o),
        .empty_o (w_req_empty),
        .full_o  (w_req_full)
    );

    mempool_link_fifo #(
        .Width (RespWidth),
        .Depth (RespDepth)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (slv_resp_i),
        .push_i  (w_resp_push),
        .pop_i   (w_resp_pop),
        .data_o  (mst_resp_o),
        .empty_o (w_resp_empty),
        .full_o  (w_resp_full)
    );

    // A transaction is outstanding from request acceptance until its response
    // leaves towards the initiator. Decrement saturates at zero.
    always_comb begin
        outstanding_d = outstanding_q;
        if (w_req_push && !w_resp_pop) begin
            outstanding_d = outstanding_q + c_OUT_W'(1);
        end else if (!w_req_push && w_resp_pop && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - c_OUT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) outstanding_q <= '0;
        else       outstanding_q <= outstanding_d;
    end

    assign outstanding_o = outstanding_q;

`ifdef MEMPOOL_LINK_STATS_EN
    logic [31:0] stall_req_cnt_q;
    logic [31:0] stall_resp_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_req_cnt_q  <= '0;
            stall_resp_cnt_q <= '0;
        end else begin
            if (mst_req_valid_i && !mst_req_ready_o)
                stall_req_cnt_q <= stall_req_cnt_q + 32'd1;
            if (mst_resp_valid_o && !mst_resp_ready_i)
                stall_resp_cnt_q <= stall_resp_cnt_q + 32'd1;
        end
    end

    assign stall_req_cnt_o  = stall_req_cnt_q;
    assign stall_resp_cnt_o = stall_resp_cnt_q;
`endif

`ifndef SYNTHESIS
    // A response leaving with nothing outstanding means the target answered
    // a request that never crossed this link.
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_resp_pop && (outstanding_q == '0)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (outstanding_q <= c_OUT_MAX));
`endif

endmodule
`default_nettype wire

// File: tb/tb_mempool_remote_link_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mempool_remote_link_buffer
//  Description : Directed self-checking bench for mempool_remote_link_buffer.
//                Inputs are driven 1 time unit after the rising edge; outputs
//                are checked at the same point. A negedge monitor logs the
//                payloads of completed output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mempool_remote_link_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] mst_req_i;
    logic        mst_req_valid_i;
    logic        mst_req_ready_o;
    logic [63:0] slv_req_o;
    logic        slv_req_valid_o;
    logic        slv_req_ready_i;
    logic [47:0] slv_resp_i;
    logic        slv_resp_valid_i;
    logic        slv_resp_ready_o;
    logic [47:0] mst_resp_o;
    logic        mst_resp_valid_o;
    logic        mst_resp_ready_i;
    logic [2:0]  outstanding_o;
`ifdef MEMPOOL_LINK_STATS_EN
    logic [31:0] stall_req_cnt_o;
    logic [31:0] stall_resp_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] req_log [$];
    logic [47:0] resp_log [$];

    always #5 clk_i = ~clk_i;

    mempool_remote_link_buffer #(
        .ReqWidth       (64),
        .RespWidth      (48),
        .ReqDepth       (2),
        .RespDepth      (4),
        .MaxOutstanding (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .mst_req_i        (mst_req_i),
        .mst_req_valid_i  (mst_req_valid_i),
        .mst_req_ready_o  (mst_req_ready_o),
        .slv_req_o        (slv_req_o),
        .slv_req_valid_o  (slv_req_valid_o),
        .slv_req_ready_i  (slv_req_ready_i),
        .slv_resp_i       (slv_resp_i),
        .slv_resp_valid_i (slv_resp_valid_i),
        .slv_resp_ready_o (slv_resp_ready_o),
        .mst_resp_o       (mst_resp_o),
        .mst_resp_valid_o (mst_resp_valid_o),
        .mst_resp_ready_i (mst_resp_ready_i),
        .outstanding_o    (outstanding_o)
`ifdef MEMPOOL_LINK_STATS_EN
        ,
        .stall_req_cnt_o  (stall_req_cnt_o),
        .stall_resp_cnt_o (stall_resp_cnt_o)
`endif
    );

    // Log payloads of handshakes that will complete on the next rising edge.
    always @(negedge clk_i) begin
        if (!rst_i && slv_req_valid_o && slv_req_ready_i)   req_log.push_back(slv_req_o);
        if (!rst_i && mst_resp_valid_o && mst_resp_ready_i) resp_log.push_back(mst_resp_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Answer every outstanding transaction and let the responses drain.
    task automatic settle();
        int n;
        n = int'(outstanding_o);
        mst_resp_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            slv_resp_i       = 48'(i);
            slv_resp_valid_i = 1'b1;
            checks++;
            if (slv_resp_ready_o !== 1'b1) begin
                errors++; $display("FAIL settle_resp_room: ready=%b expected 1", slv_resp_ready_o);
            end
            tick();
        end
        slv_resp_valid_i = 1'b0;
        for (int k = 0; k < 10 && mst_resp_valid_o; k++) tick();
        checks++;
        if (outstanding_o !== 3'd0 || mst_resp_valid_o !== 1'b0) begin
            errors++; $display("FAIL settle: outstanding=%0d resp_valid=%b expected 0/0",
                               outstanding_o, mst_resp_valid_o);
        end
        mst_resp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; mst_req_i = '0; mst_req_valid_i = 1'b0; slv_req_ready_i = 1'b0;
        slv_resp_i = '0; slv_resp_valid_i = 1'b0; mst_resp_ready_i = 1'b0;
        tick(); tick();
        checks++;
        if (mst_req_ready_o !== 1'b0 || slv_resp_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready: req_ready=%b resp_ready=%b expected 0/0",
                               mst_req_ready_o, slv_resp_ready_o);
        end
        checks++;
        if (slv_req_valid_o !== 1'b0 || mst_resp_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: req_valid=%b resp_valid=%b expected 0/0",
                               slv_req_valid_o, mst_resp_valid_o);
        end
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding_o);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if (mst_req_ready_o !== 1'b1 || slv_resp_ready_o !== 1'b1) begin
            errors++; $display("FAIL post_reset_ready: req_ready=%b resp_ready=%b expected 1/1",
                               mst_req_ready_o, slv_resp_ready_o);
        end
    endtask

    task automatic test_single();
        slv_req_ready_i = 1'b1; mst_resp_ready_i = 1'b0;
        tick();
        mst_req_i = 64'hA5; mst_req_valid_i = 1'b1;
        tick();
        mst_req_valid_i = 1'b0;
        checks++;
        if (slv_req_valid_o !== 1'b1 || slv_req_o !== 64'hA5) begin
            errors++; $display("FAIL single_req: valid=%b data=%0h expected 1/a5", slv_req_valid_o, slv_req_o);
        end
        checks++;
        if (outstanding_o !== 3'd1) begin
            errors++; $display("FAIL single_outstanding: got %0d expected 1", outstanding_o);
        end
        tick();
        checks++;
        if (slv_req_valid_o !== 1'b0) begin
            errors++; $display("FAIL single_req_drained: valid=%b expected 0", slv_req_valid_o);
        end
        slv_resp_i = 48'h3C; slv_resp_valid_i = 1'b1;
        tick();
        slv_resp_valid_i = 1'b0;
        checks++;
        if (mst_resp_valid_o !== 1'b1 || mst_resp_o !== 48'h3C || outstanding_o !== 3'd1) begin
            errors++; $display("FAIL single_resp: valid=%b data=%0h outstanding=%0d expected 1/3c/1",
                               mst_resp_valid_o, mst_resp_o, outstanding_o);
        end
        mst_resp_ready_i = 1'b1;
        tick();
        mst_resp_ready_i = 1'b0;
        checks++;
        if (mst_resp_valid_o !== 1'b0 || outstanding_o !== 3'd0) begin
            errors++; $display("FAIL single_done: valid=%b outstanding=%0d expected 0/0",
                               mst_resp_valid_o, outstanding_o);
        end
    endtask

    task automatic test_backpressure();
        slv_req_ready_i = 1'b0;
        mst_req_i = 64'h1111; mst_req_valid_i = 1'b1;
        tick();
        mst_req_i = 64'h2222;
        tick();
        mst_req_i = 64'h3333;  // offered, must be held off by a full FIFO
        tick(); tick();
        checks++;
        if (mst_req_ready_o !== 1'b0 || outstanding_o !== 3'd2) begin
            errors++; $display("FAIL bp_full: ready=%b outstanding=%0d expected 0/2",
                               mst_req_ready_o, outstanding_o);
        end
        slv_req_ready_i = 1'b1;
        checks++;
        if (slv_req_valid_o !== 1'b1 || slv_req_o !== 64'h1111) begin
            errors++; $display("FAIL bp_first: valid=%b data=%0h expected 1/1111", slv_req_valid_o, slv_req_o);
        end
        tick();
        checks++;
        if (slv_req_o !== 64'h2222 || mst_req_ready_o !== 1'b1) begin
            errors++; $display("FAIL bp_second: data=%0h ready=%b expected 2222/1", slv_req_o, mst_req_ready_o);
        end
        tick();
        mst_req_valid_i = 1'b0;
        checks++;
        if (slv_req_o !== 64'h3333 || outstanding_o !== 3'd3) begin
            errors++; $display("FAIL bp_third: data=%0h outstanding=%0d expected 3333/3", slv_req_o, outstanding_o);
        end
        tick();
        checks++;
        if (slv_req_valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_drained: valid=%b expected 0", slv_req_valid_o);
        end
        settle();
    endtask

    task automatic test_outstanding_limit();
        slv_req_ready_i = 1'b1; mst_resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mst_req_i = 64'(16'hB000 + i); mst_req_valid_i = 1'b1;
            for (int k = 0; k < 10 && !mst_req_ready_o; k++) tick();
            checks++;
            if (mst_req_ready_o !== 1'b1) begin
                errors++; $display("FAIL limit_accept: ready=%b expected 1 (req %0d)", mst_req_ready_o, i);
            end
            tick();
        end
        mst_req_valid_i = 1'b0;
        tick();
        checks++;
        if (outstanding_o !== 3'd4 || mst_req_ready_o !== 1'b0) begin
            errors++; $display("FAIL limit_reached: outstanding=%0d ready=%b expected 4/0",
                               outstanding_o, mst_req_ready_o);
        end
        slv_resp_i = 48'hC0; slv_resp_valid_i = 1'b1;
        tick();
        slv_resp_valid_i = 1'b0;
        checks++;
        if (mst_resp_valid_o !== 1'b1 || outstanding_o !== 3'd4 || mst_req_ready_o !== 1'b0) begin
            errors++; $display("FAIL limit_resp_buffered: valid=%b outstanding=%0d ready=%b expected 1/4/0",
                               mst_resp_valid_o, outstanding_o, mst_req_ready_o);
        end
        mst_resp_ready_i = 1'b1;
        tick();
        mst_resp_ready_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd3 || mst_req_ready_o !== 1'b1) begin
            errors++; $display("FAIL limit_release: outstanding=%0d ready=%b expected 3/1",
                               outstanding_o, mst_req_ready_o);
        end
    endtask

    task automatic test_simultaneous();
        // Outstanding is 3 here; buffer two responses and pop one -> 2 left.
        slv_resp_valid_i = 1'b1; slv_resp_i = 48'hD1;
        tick();
        slv_resp_i = 48'hD2;
        tick();
        slv_resp_valid_i = 1'b0;
        mst_resp_ready_i = 1'b1;
        tick();
        mst_resp_ready_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd2 || mst_resp_valid_o !== 1'b1) begin
            errors++; $display("FAIL simul_setup: outstanding=%0d resp_valid=%b expected 2/1",
                               outstanding_o, mst_resp_valid_o);
        end
        mst_req_i = 64'hE0; mst_req_valid_i = 1'b1; mst_resp_ready_i = 1'b1;
        tick();
        mst_req_valid_i = 1'b0; mst_resp_ready_i = 1'b0;
        checks++;
        if (outstanding_o !== 3'd2) begin
            errors++; $display("FAIL simul_count: outstanding=%0d expected 2", outstanding_o);
        end
        tick();
        settle();
    endtask

    task automatic test_wrap();
        logic [63:0] exp_req [$];
        logic [47:0] exp_resp [$];
        logic [63:0] t;
        int rbase;
        int sbase;
        rbase = req_log.size(); sbase = resp_log.size();
        slv_req_ready_i = 1'b1; mst_resp_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            t = {$urandom, $urandom};
            exp_req.push_back(t);
            mst_req_i = t; mst_req_valid_i = 1'b1;
            for (int k = 0; k < 10 && !mst_req_ready_o; k++) tick();
            tick();
            mst_req_valid_i = 1'b0;
            tick();
            t = {$urandom, $urandom};
            exp_resp.push_back(t[47:0]);
            slv_resp_i = t[47:0]; slv_resp_valid_i = 1'b1;
            tick();
            slv_resp_valid_i = 1'b0;
            tick();
        end
        tick(); tick();
        mst_resp_ready_i = 1'b0;
        checks++;
        if (req_log.size() - rbase != 8 || resp_log.size() - sbase != 8) begin
            errors++; $display("FAIL wrap_counts: req=%0d resp=%0d expected 8/8",
                               req_log.size() - rbase, resp_log.size() - sbase);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (req_log[rbase+i] !== exp_req[i]) begin
                    errors++; $display("FAIL wrap_req[%0d]: got %0h expected %0h", i, req_log[rbase+i], exp_req[i]);
                end
                checks++;
                if (resp_log[sbase+i] !== exp_resp[i]) begin
                    errors++; $display("FAIL wrap_resp[%0d]: got %0h expected %0h", i, resp_log[sbase+i], exp_resp[i]);
                end
            end
        end
        checks++;
        if (outstanding_o !== 3'd0) begin
            errors++; $display("FAIL wrap_outstanding: got %0d expected 0", outstanding_o);
        end
    endtask

    task automatic test_reset_mid();
        int rbase;
        int sbase;
        slv_req_ready_i = 1'b0; mst_resp_ready_i = 1'b0;
        mst_req_i = 64'hF1; mst_req_valid_i = 1'b1;
        tick();
        mst_req_i = 64'hF2;
        tick();
        mst_req_valid_i = 1'b0;
        slv_resp_i = 48'hF3; slv_resp_valid_i = 1'b1;
        tick();
        slv_resp_valid_i = 1'b0;
        checks++;
        if (slv_req_valid_o !== 1'b1 || mst_resp_valid_o !== 1'b1 || outstanding_o !== 3'd2) begin
            errors++; $display("FAIL rstmid_setup: req_valid=%b resp_valid=%b outstanding=%0d expected 1/1/2",
                               slv_req_valid_o, mst_resp_valid_o, outstanding_o);
        end
        rbase = req_log.size(); sbase = resp_log.size();
        rst_i = 1'b1;
        #1;
        checks++;
        if (slv_resp_ready_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready: resp_ready=%b expected 0", slv_resp_ready_o);
        end
        tick();
        rst_i = 1'b0;
        checks++;
        if (slv_req_valid_o !== 1'b0 || mst_resp_valid_o !== 1'b0 || outstanding_o !== 3'd0) begin
            errors++; $display("FAIL rstmid_clear: req_valid=%b resp_valid=%b outstanding=%0d expected 0/0/0",
                               slv_req_valid_o, mst_resp_valid_o, outstanding_o);
        end
        slv_req_ready_i = 1'b1; mst_resp_ready_i = 1'b1;
        tick(); tick(); tick(); tick();
        mst_resp_ready_i = 1'b0;
        checks++;
        if (req_log.size() != rbase || resp_log.size() != sbase) begin
            errors++; $display("FAIL rstmid_stale: req=%0d resp=%0d new transfers, expected 0/0",
                               req_log.size() - rbase, resp_log.size() - sbase);
        end
    endtask

`ifdef MEMPOOL_LINK_STATS_EN
    task automatic test_stats();
        checks++;
        if (stall_req_cnt_o !== 32'd0 || stall_resp_cnt_o !== 32'd0) begin
            errors++; $display("FAIL stats_reset: req=%0d resp=%0d expected 0/0", stall_req_cnt_o, stall_resp_cnt_o);
        end
        slv_req_ready_i = 1'b0;
        mst_req_i = 64'h51; mst_req_valid_i = 1'b1;
        tick();
        mst_req_i = 64'h52;
        tick();
        mst_req_i = 64'h53;
        repeat (5) tick();
        checks++;
        if (stall_req_cnt_o !== 32'd5) begin
            errors++; $display("FAIL stats_req: got %0d expected 5", stall_req_cnt_o);
        end
        slv_req_ready_i = 1'b1;
        for (int k = 0; k < 10 && !mst_req_ready_o; k++) tick();
        tick();
        mst_req_valid_i = 1'b0;
        tick(); tick();
        slv_resp_i = 48'h54; slv_resp_valid_i = 1'b1;
        tick();
        slv_resp_valid_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (stall_resp_cnt_o !== 32'd3) begin
            errors++; $display("FAIL stats_resp: got %0d expected 3", stall_resp_cnt_o);
        end
        mst_resp_ready_i = 1'b1;
        tick();
        mst_resp_ready_i = 1'b0;
        settle();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_outstanding_limit();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
`ifdef MEMPOOL_LINK_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
